// File: rtl/mem_byte_bridge_pkg.sv
// mem_byte_bridge_pkg: shared widths, lane count and FSM state encoding
// for the word-to-byte memory bridge.
package mem_byte_bridge_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int MBB_LANES  = 4;

    // Index of the final lane; the beat that ends it closes the transfer.
    localparam logic [1:0] MBB_LAST_LANE = 2'(MBB_LANES - 1);

    typedef enum logic [1:0] {
        MBB_IDLE = 2'd0,
        MBB_BEAT = 2'd1,
        MBB_DONE = 2'd2
    } mbb_state_e;

endpackage : mem_byte_bridge_pkg

// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: accepts word-wide read/write requests from the core's
// data port and serialises them as four byte beats on an 8-bit external
// bus, stalling the core until the word is complete.
//
// Optional feature macro: MEM_WAIT_EN
//   defined   -> ext_ready_i exists; a beat ends only on an edge where
//                ext_ready_i is high, outputs hold steady until then.
//   undefined -> every beat lasts exactly one cycle.
module mem_byte_bridge
    import mem_byte_bridge_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  read_op_i,
    input  logic                  write_op_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            mask_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] ext_addr_o,
    output logic [7:0]            ext_data_o,
    input  logic [7:0]            ext_data_i,
    output logic                  ext_we_o,
    output logic                  ext_re_o
`ifdef MEM_WAIT_EN
    ,
    input  logic                  ext_ready_i
`endif
);

    // Registered state
    mbb_state_e              state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [ADDR_WIDTH-3:0]   waddr_q, waddr_d;   // word address, addr[31:2]
    logic [3:0]              mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_wr_q, is_wr_d;
    logic [23:0]             rbuf_q, rbuf_d;     // lanes 0..2; lane 3 lands directly in data_o
    logic [DATA_WIDTH-1:0]   data_o_q, data_o_d;

    // Combinational outputs decoded from the state
    logic                    stall_s;
    logic [ADDR_WIDTH-1:0]   ext_addr_s;
    logic [7:0]              ext_data_s;
    logic                    ext_we_s;
    logic                    ext_re_s;
    logic                    beat_end_s;
    logic                    req_s;
    logic                    unused_addr_lsb_s;

    // The byte offset of the core address is meaningless for word accesses.
    assign unused_addr_lsb_s = ^addr_i[1:0];

    assign req_s = read_op_i | write_op_i;

`ifdef MEM_WAIT_EN
    assign beat_end_s = ext_ready_i;
`else
    assign beat_end_s = 1'b1;
`endif

    // State, latched request and read data registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= MBB_IDLE;
            lane_q   <= 2'd0;
            waddr_q  <= '0;
            mask_q   <= 4'd0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            rbuf_q   <= 24'd0;
            data_o_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            waddr_q  <= waddr_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            rbuf_q   <= rbuf_d;
            data_o_q <= data_o_d;
        end
    end

    // Next-state logic, request capture, beat strobes and read assembly
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        waddr_d    = waddr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        rbuf_d     = rbuf_q;
        data_o_d   = data_o_q;
        stall_s    = 1'b0;
        ext_addr_s = '0;
        ext_data_s = 8'd0;
        ext_we_s   = 1'b0;
        ext_re_s   = 1'b0;

        case (state_q)
            MBB_IDLE: begin
                if (req_s) begin
                    // Stall in the same cycle the request appears; a
                    // simultaneous read and write resolves to the write.
                    stall_s = 1'b1;
                    waddr_d = addr_i[ADDR_WIDTH-1:2];
                    mask_d  = mask_i;
                    wdata_d = data_i;
                    is_wr_d = write_op_i;
                    lane_d  = 2'd0;
                    state_d = MBB_BEAT;
                end else begin
                    state_d = MBB_IDLE;
                end
            end

            MBB_BEAT: begin
                stall_s    = 1'b1;
                ext_addr_s = {waddr_q, lane_q};
                if (is_wr_q) begin
                    // A masked-off lane still occupies its beat, strobe low.
                    ext_we_s = mask_q[lane_q];
                    case (lane_q)
                        2'd0:    ext_data_s = wdata_q[7:0];
                        2'd1:    ext_data_s = wdata_q[15:8];
                        2'd2:    ext_data_s = wdata_q[23:16];
                        2'd3:    ext_data_s = wdata_q[31:24];
                        default: ext_data_s = 8'd0;
                    endcase
                end else begin
                    ext_re_s = 1'b1;
                end

                if (beat_end_s) begin
                    if (!is_wr_q) begin
                        case (lane_q)
                            2'd0:    rbuf_d[7:0]   = ext_data_i;
                            2'd1:    rbuf_d[15:8]  = ext_data_i;
                            2'd2:    rbuf_d[23:16] = ext_data_i;
                            2'd3:    data_o_d      = {ext_data_i, rbuf_q};
                            default: rbuf_d        = rbuf_q;
                        endcase
                    end else begin
                        data_o_d = data_o_q;
                    end

                    if (lane_q == MBB_LAST_LANE) begin
                        lane_d  = 2'd0;
                        state_d = MBB_DONE;
                    end else begin
                        lane_d  = lane_q + 2'd1;
                        state_d = MBB_BEAT;
                    end
                end else begin
                    state_d = MBB_BEAT;
                end
            end

            MBB_DONE: begin
                // The core still shows the finished request here; ignore it.
                state_d = MBB_IDLE;
            end

            default: begin
                state_d = MBB_IDLE;
                lane_d  = 2'd0;
            end
        endcase
    end

    // stall_o must read low while reset is applied, even with a request held.
    assign stall_o    = stall_s & ~RST;
    assign data_o     = data_o_q;
    assign ext_addr_o = ext_addr_s;
    assign ext_data_o = ext_data_s;
    assign ext_we_o   = ext_we_s;
    assign ext_re_o   = ext_re_s;

endmodule : mem_byte_bridge

// File: doc/mem_byte_bridge.md
# mem_byte_bridge

Responder for the core's data-memory port: accepts the core's word-wide read/write requests and serialises them onto a byte-wide external memory bus. It stalls the core while a transfer is in progress. It sits between the core's data port and an 8-bit external SRAM/peripheral, replacing the single-cycle data RAM where memory is narrow or slow.

## Interface
Parameters:
- none; widths come from `ADDR_WIDTH` / `DATA_WIDTH` in config.vh, both 32 bits.

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- read_op_i  in  1  core read request, held by the core while stall_o=1
- write_op_i  in  1  core write request, held by the core while stall_o=1
- addr_i  in  32  byte address; bits [1:0] ignored
- mask_i  in  4  write byte enables; bit k selects data_i[8k+7:8k]; ignored on reads
- data_i  in  32  write data from the core
- data_o  out  32  read data to the core
- stall_o  out  1  core must freeze and hold its request while high
- ext_addr_o  out  32  external byte address
- ext_data_o  out  8  external write byte
- ext_data_i  in  8  external read byte, combinational, valid during ext_re_o
- ext_we_o  out  1  external write strobe
- ext_re_o  out  1  external read strobe
- ext_ready_i  in  1  beat complete; present only with MEM_WAIT_EN

## Operation
- FSM states: IDLE, BEAT, DONE; a 2-bit lane counter runs lanes 0..3.
- IDLE:
  - read_op_i or write_op_i high: stall_o=1 combinationally in the same cycle; latch addr, mask, data and op; lane=0; go to BEAT.
  - Both ops high: the write wins; no read is performed.
- BEAT, one external byte per beat:
  - ext_addr_o = {addr[31:2], lane}.
  - Write beat: ext_we_o=mask[lane] and ext_data_o=data[8*lane+7:8*lane]. A masked-off lane still spends its beat with both strobes low.
  - Read beat: ext_re_o=1. ext_data_i is captured into byte `lane` of the read buffer at the edge that ends the beat.
  - After lane 3 ends, go to DONE.
  - stall_o=1 throughout BEAT.
- DONE:
  - stall_o=0 for exactly one cycle. For a read, data_o presents the assembled word.
  - Core inputs are ignored in DONE, because they still show the finished request.
  - Go to IDLE.
- data_o holds its value until the next read completes; writes do not change it.
- Read byte order: little-endian, lane 0 = data_o[7:0].

## Timing
- Reset values (asynchronous, take effect immediately):
  - State IDLE, lane 0.
  - data_o=0, stall_o=0.
  - ext_addr_o=0, ext_data_o=0, ext_we_o=0, ext_re_o=0.
- Latency without MEM_WAIT_EN, with the request first seen in cycle 0:
  - Cycles 0..4: stall_o=1.
  - Cycles 1..4: beats for lanes 0..3.
  - Cycle 5: DONE, stall_o=0.
  - Cycle 6: IDLE, and a new request may start.
- Throughput: one word per 6 cycles for back-to-back requests.
- Strobes are asserted only in BEAT, never in IDLE or DONE.
- Reset mid-transfer: the transfer is aborted with no further beats. A partially written word stays partially written, and the read buffer is cleared.

## Configuration
- MEM_WAIT_EN defined:
  - The ext_ready_i port exists.
  - A beat ends only at an edge where ext_ready_i=1; until then ext_addr_o, ext_data_o and the strobes hold steady.
  - Read data is captured at that edge.
  - Latency grows by the number of wait cycles; stall_o stays high throughout.
- MEM_WAIT_EN undefined:
  - No ext_ready_i port.
  - Every beat is exactly one cycle.

## Structure
- Shared definitions go in config.vh:
  - state encodings `MBB_IDLE`, `MBB_BEAT`, `MBB_DONE`;
  - lane-count constant `MBB_LANES` = 4.
- Single module, no sub-module. The lane mux and read-buffer byte-insert stay inline.

## Test plan
- Read of 0x0000_0100, external bytes 0x11,0x22,0x33,0x44 at 0x100..0x103 -> stall_o high for cycles 0..4, data_o=0x4433_2211 in cycle 5, ext_re_o high only in cycles 1..4.
- Write of 0xDEAD_BEEF, mask 4'b1111, to 0x200 -> ext_we_o on 0x200..0x203 with 0xEF,0xBE,0xAD,0xDE; data_o unchanged.
- Write with mask 4'b0101 to 0x300 -> strobes only on 0x300 and 0x302; beats at 0x301 and 0x303 with ext_we_o=0; total stall still 5 cycles.
- read_op_i and write_op_i both high -> write performed, no ext_re_o pulse; back-to-back read next presented in cycle 6, starting correctly.
- RST pulsed during the lane-2 beat of a write -> all outputs zero immediately, state IDLE, lanes 2..3 never written; the next request completes normally.
- MEM_WAIT_EN: ext_ready_i low for 3 cycles on lane 1 -> ext_addr_o holds lane-1 address for 4 cycles, stall_o high for 8 cycles, correct data_o.
